// File: rtl/stack_unit.sv
// LIFO operand stack: one push/pop/replace per cycle, combinational top-of-stack,
// sticky overflow/underflow flags cleared by err_clr.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_idx;

    // Low AW bits minus one wraps to DEPTH-1 when full; the empty case is masked below.
    assign top_idx = count_q[AW-1:0] - AW'(1);

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign dout  = empty ? '0 : mem_q[top_idx];
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        unique case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    count_d = count_q + ONE_CNT;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    count_d = count_q - ONE_CNT;
                end else begin
                    udf_d = 1'b1;
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (empty) begin
                    count_d = ONE_CNT;
                end else begin
                    wr_addr = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_addr] <= din;
        end
    end

endmodule
